// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input reorder path: default frame size,
// bit-reverse helper and RAM address field layout {bank, ch, idx}.
package fft_pkg;

    localparam int BW_FFTP_DEFAULT = 9;
    localparam int REV_MAX_W       = 32;

    // Reverses the low 'width' bits of x; bits at and above 'width' return 0.
    function automatic logic [REV_MAX_W-1:0] rev(input logic [REV_MAX_W-1:0] x, input int width);
        logic [REV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_MAX_W; i++) begin
            if (i < width) r[i] = x[width-1-i];
        end
        return r;
    endfunction

    function automatic int addr_w(input int chb, input int bw_fftp);
        return 1 + chb + bw_fftp;
    endfunction

    function automatic int idx_lsb();
        return 0;
    endfunction

    function automatic int ch_lsb(input int bw_fftp);
        return bw_fftp;
    endfunction

    function automatic int bank_bit(input int chb, input int bw_fftp);
        return chb + bw_fftp;
    endfunction

endpackage

// File: rtl/bitrev_addr_gen.sv
// Frame counter split into channel and sample-index fields, with terminal
// count and an optionally bit-reversed index for address generation.
module bitrev_addr_gen
    import fft_pkg::*;
#(
    parameter int IDX_W    = BW_FFTP_DEFAULT,
    parameter int CH_W     = 1,
    parameter bit CH_MAJOR = 1'b0,
    parameter bit REV      = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] idx_addr,
    output logic [CH_W-1:0]  ch,
    output logic             tc
);

    localparam int CW = IDX_W + CH_W;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [REV_MAX_W-1:0] rev_full;
    logic                 rev_unused;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CW'(1);
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    generate
        if (CH_MAJOR) begin : g_ch_major
            assign ch  = cnt_q[CW-1 -: CH_W];
            assign idx = cnt_q[IDX_W-1:0];
        end else begin : g_ch_minor
            assign ch  = cnt_q[CH_W-1:0];
            assign idx = cnt_q[CW-1 -: IDX_W];
        end
    endgenerate

    assign rev_full   = rev(REV_MAX_W'(idx), IDX_W);
    assign rev_unused = ^rev_full[REV_MAX_W-1:IDX_W];
    assign idx_addr   = REV ? rev_full[IDX_W-1:0] : idx;
    assign tc         = &cnt_q;

endmodule

// File: rtl/bitrev_pingpong_ctrl.sv
// Ping-pong reorder buffer controller: fills one bank with interleaved
// samples while the other bank is read out per channel in FFT order.
module bitrev_pingpong_ctrl
    import fft_pkg::*;
#(
    parameter  int BW_FFTP   = BW_FFTP_DEFAULT,
    parameter  int N_CH      = 2,
    parameter  bit REV_ON_RD = 1'b1,
    localparam int CHB       = $clog2(N_CH),
    localparam int AW        = addr_w(CHB, BW_FFTP)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          ClockEn,
    input  logic          Flush,
    input  logic          InValid,
    output logic          InReady,
    output logic          WE,
    output logic [AW-1:0] WrAddress,
    input  logic          OutReady,
    output logic          RdEn,
    output logic [AW-1:0] RdAddress,
    output logic          FrameStart,
    output logic          FrameLast,
    output logic [CHB-1:0] ChOut
);

    logic [1:0]         full_q, full_d;
    logic               wb_q, wb_d, rb_q, rb_d;
    logic               we_q, we_d, rd_en_q, rd_en_d;
    logic               fs_q, fs_d, fl_q, fl_d;
    logic [AW-1:0]      wr_address_q, wr_address_d, rd_address_q, rd_address_d;
    logic [CHB-1:0]     ch_out_q, ch_out_d;

    logic               wr_acc, rd_iss, clr;
    logic [BW_FFTP-1:0] w_idx_unused, w_idx_addr, r_idx, r_idx_addr;
    logic [CHB-1:0]     w_ch, r_ch;
    logic               w_tc, r_tc;

    // Flush only acts on enabled cycles so ClockEn low freezes it as well.
    assign clr     = ClockEn & Flush;
    assign InReady = ~full_q[wb_q];
    assign wr_acc  = InValid & InReady & ClockEn & ~Flush;
    assign rd_iss  = full_q[rb_q] & OutReady & ClockEn & ~Flush;

    bitrev_addr_gen #(
        .IDX_W(BW_FFTP), .CH_W(CHB), .CH_MAJOR(1'b0), .REV(!REV_ON_RD)
    ) u_wr_gen (
        .Clock(Clock), .Reset(Reset), .en(wr_acc), .clr(clr),
        .idx(w_idx_unused), .idx_addr(w_idx_addr), .ch(w_ch), .tc(w_tc)
    );

    bitrev_addr_gen #(
        .IDX_W(BW_FFTP), .CH_W(CHB), .CH_MAJOR(1'b1), .REV(REV_ON_RD)
    ) u_rd_gen (
        .Clock(Clock), .Reset(Reset), .en(rd_iss), .clr(clr),
        .idx(r_idx), .idx_addr(r_idx_addr), .ch(r_ch), .tc(r_tc)
    );

    always_comb begin
        full_d       = full_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        we_d         = we_q;
        rd_en_d      = rd_en_q;
        fs_d         = fs_q;
        fl_d         = fl_q;
        wr_address_d = wr_address_q;
        rd_address_d = rd_address_q;
        ch_out_d     = ch_out_q;
        if (ClockEn) begin
            if (Flush) begin
                full_d  = '0;
                wb_d    = 1'b0;
                rb_d    = 1'b0;
                we_d    = 1'b0;
                rd_en_d = 1'b0;
                fs_d    = 1'b0;
                fl_d    = 1'b0;
            end else begin
                we_d    = wr_acc;
                rd_en_d = rd_iss;
                fs_d    = rd_iss & (r_idx == '0);
                fl_d    = rd_iss & (&r_idx);
                if (wr_acc) begin
                    wr_address_d = {wb_q, w_ch, w_idx_addr};
                    if (w_tc) begin
                        full_d[wb_q] = 1'b1;
                        wb_d         = ~wb_q;
                    end
                end
                // A completing read always targets the other bank from a completing write.
                if (rd_iss) begin
                    rd_address_d = {rb_q, r_ch, r_idx_addr};
                    ch_out_d     = r_ch;
                    if (r_tc) begin
                        full_d[rb_q] = 1'b0;
                        rb_d         = ~rb_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            full_q       <= '0;
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            we_q         <= 1'b0;
            rd_en_q      <= 1'b0;
            fs_q         <= 1'b0;
            fl_q         <= 1'b0;
            wr_address_q <= '0;
            rd_address_q <= '0;
            ch_out_q     <= '0;
        end else begin
            full_q       <= full_d;
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            we_q         <= we_d;
            rd_en_q      <= rd_en_d;
            fs_q         <= fs_d;
            fl_q         <= fl_d;
            wr_address_q <= wr_address_d;
            rd_address_q <= rd_address_d;
            ch_out_q     <= ch_out_d;
        end
    end

    assign WE         = we_q;
    assign WrAddress  = wr_address_q;
    assign RdEn       = rd_en_q;
    assign RdAddress  = rd_address_q;
    assign FrameStart = fs_q;
    assign FrameLast  = fl_q;
    assign ChOut      = ch_out_q;

endmodule

// File: tb/tb_bitrev_pingpong_ctrl.sv
// Scoreboard bench: two controllers (read-reversed and write-reversed) share
// stimulus; a frame-count model predicts handshakes and RAM addresses.
module tb_bitrev_pingpong_ctrl;

    localparam int AW = 5;
    localparam int FR = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          ch;
        logic          fs;
        logic          fl;
    } rd_t;

    logic          Clock = 1'b0;
    logic          Reset, ClockEn, Flush, InValid, OutReady;
    logic          in_ready [2];
    logic          we       [2];
    logic          rd_en    [2];
    logic          fs       [2];
    logic          fl       [2];
    logic          ch       [2];
    logic [AW-1:0] wa       [2];
    logic [AW-1:0] ra       [2];

    logic [AW-1:0] wq [2][$];
    rd_t           rq [2][$];

    int checks = 0;
    int failures = 0;
    int we_seen = 0;
    int wcount = 0;
    int rcount = 0;

    always #5 Clock = ~Clock;

    bitrev_pingpong_ctrl #(.BW_FFTP(3), .N_CH(2), .REV_ON_RD(1'b1)) dut_rd (
        .Clock(Clock), .Reset(Reset), .ClockEn(ClockEn), .Flush(Flush),
        .InValid(InValid), .InReady(in_ready[0]), .WE(we[0]), .WrAddress(wa[0]),
        .OutReady(OutReady), .RdEn(rd_en[0]), .RdAddress(ra[0]),
        .FrameStart(fs[0]), .FrameLast(fl[0]), .ChOut(ch[0])
    );

    bitrev_pingpong_ctrl #(.BW_FFTP(3), .N_CH(2), .REV_ON_RD(1'b0)) dut_wr (
        .Clock(Clock), .Reset(Reset), .ClockEn(ClockEn), .Flush(Flush),
        .InValid(InValid), .InReady(in_ready[1]), .WE(we[1]), .WrAddress(wa[1]),
        .OutReady(OutReady), .RdEn(rd_en[1]), .RdAddress(ra[1]),
        .FrameStart(fs[1]), .FrameLast(fl[1]), .ChOut(ch[1])
    );

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] rev3(input logic [2:0] x);
        return {x[0], x[1], x[2]};
    endfunction

    // Instance 0 writes natural order; instance 1 writes bit-reversed.
    function automatic logic [AW-1:0] exp_waddr(input int d, input int w);
        int i;
        logic bank, c;
        logic [2:0] n;
        i    = w % FR;
        bank = 1'((w / FR) % 2);
        c    = 1'(i % 2);
        n    = 3'(i / 2);
        return {bank, c, (d == 0) ? n : rev3(n)};
    endfunction

    function automatic rd_t exp_rd(input int d, input int r);
        int i;
        logic bank, c;
        logic [2:0] k;
        rd_t e;
        i      = r % FR;
        bank   = 1'((r / FR) % 2);
        c      = 1'(i / 8);
        k      = 3'(i % 8);
        e.addr = {bank, c, (d == 0) ? rev3(k) : k};
        e.ch   = c;
        e.fs   = (k == 3'd0);
        e.fl   = (k == 3'd7);
        return e;
    endfunction

    function automatic bit m_ready();
        return (wcount / FR - rcount / FR) < 2;
    endfunction

    function automatic bit m_can_read();
        return (wcount / FR) > (rcount / FR);
    endfunction

    // Called at a negedge; drives one cycle of stimulus and ends at the next negedge.
    task automatic step(input bit iv, input bit ordy, input bit ce = 1'b1, input bit fls = 1'b0);
        bit acc, iss;
        InValid  = iv;
        OutReady = ordy;
        ClockEn  = ce;
        Flush    = fls;
        for (int d = 0; d < 2; d++)
            check(in_ready[d] == m_ready(), $sformatf("in_ready%0d", d), 32'(in_ready[d]), 32'(m_ready()));
        if (ce) begin
            if (fls) begin
                wcount = 0;
                rcount = 0;
            end else begin
                acc = iv && m_ready();
                iss = ordy && m_can_read();
                for (int d = 0; d < 2; d++) begin
                    if (acc) wq[d].push_back(exp_waddr(d, wcount));
                    if (iss) rq[d].push_back(exp_rd(d, rcount));
                end
                if (acc) wcount++;
                if (iss) rcount++;
            end
        end
        @(negedge Clock);
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        ClockEn  = 1'b1;
        Flush    = 1'b0;
        wcount   = 0;
        rcount   = 0;
        for (int d = 0; d < 2; d++) begin
            wq[d].delete();
            rq[d].delete();
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check({we[d], rd_en[d], fs[d], fl[d], ch[d]} == 5'b0, "reset_strobes",
                  32'({we[d], rd_en[d], fs[d], fl[d], ch[d]}), 32'h0);
            check(wa[d] == '0 && ra[d] == '0, "reset_addr", 32'({wa[d], ra[d]}), 32'h0);
            check(in_ready[d] == 1'b1, "reset_in_ready", 32'(in_ready[d]), 32'h1);
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Monitor: after each edge, an enabled cycle must show exactly the queued
    // transaction (or idle strobes); a disabled cycle must hold every output.
    logic [2*AW+4:0] prev [2];
    always @(posedge Clock) begin
        bit ce_e, rst_e;
        logic [AW-1:0] ew;
        rd_t er;
        ce_e  = ClockEn;
        rst_e = Reset;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_e && !Reset) begin
                if (ce_e) begin
                    if (wq[d].size() > 0) begin
                        ew = wq[d].pop_front();
                        check(we[d] && wa[d] == ew, $sformatf("write%0d", d), 32'({we[d], wa[d]}), 32'({1'b1, ew}));
                        if (d == 0 && we[d]) we_seen++;
                    end else begin
                        check(!we[d], $sformatf("we_idle%0d", d), 32'(we[d]), 32'h0);
                    end
                    if (rq[d].size() > 0) begin
                        er = rq[d].pop_front();
                        check(rd_en[d] && {ra[d], ch[d], fs[d], fl[d]} == er, $sformatf("read%0d", d),
                              32'({rd_en[d], ra[d], ch[d], fs[d], fl[d]}), 32'({1'b1, er}));
                    end else begin
                        check({rd_en[d], fs[d], fl[d]} == 3'b0, $sformatf("rd_idle%0d", d),
                              32'({rd_en[d], fs[d], fl[d]}), 32'h0);
                    end
                end else begin
                    check({we[d], rd_en[d], fs[d], fl[d], ch[d], wa[d], ra[d]} == prev[d],
                          $sformatf("ce_hold%0d", d),
                          32'({we[d], rd_en[d], fs[d], fl[d], ch[d], wa[d], ra[d]}), 32'(prev[d]));
                end
            end
            prev[d] = {we[d], rd_en[d], fs[d], fl[d], ch[d], wa[d], ra[d]};
        end
    end

    initial begin
        int we0;
        do_reset();

        // Reset mid-frame after 5 writes; the next write must restart at 0x00.
        for (int i = 0; i < 5; i++) step(1, 0);
        do_reset();

        // Fill bank 0, then read it out in bit-reversed channel frames.
        for (int i = 0; i < 16; i++) step(1, 1);
        for (int i = 0; i < 20; i++) step(0, 1);

        // Back-pressure: 40 offered samples with reads stalled.
        step(0, 0, 1, 1);
        we0 = we_seen;
        for (int i = 0; i < 40; i++) step(1, 0);
        check(we_seen - we0 == 32, "accepted_under_backpressure", 32'(we_seen - we0), 32'd32);
        check(in_ready[0] == 1'b0, "in_ready_low_both_full", 32'(in_ready[0]), 32'h0);
        for (int i = 0; i < 36; i++) step(0, 1);

        // Continuous flow: last write of bank 1 coincides with last read of bank 0.
        step(0, 0, 1, 1);
        for (int i = 0; i < 40; i++) step(1, 1);
        for (int i = 0; i < 30; i++) step(0, 1);

        // ClockEn low for 3 cycles mid-read.
        step(0, 0, 1, 1);
        for (int i = 0; i < 16; i++) step(1, 0);
        for (int i = 0; i < 3; i++) step(0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 16; i++) step(0, 1);

        // Flush mid-frame: nothing readable until a fresh 16-sample fill.
        for (int i = 0; i < 20; i++) step(1, 1);
        step(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1);
        for (int i = 0; i < 16; i++) step(1, 1);
        for (int i = 0; i < 20; i++) step(0, 1);

        // Randomised traffic with occasional stalls, enables and flushes.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);

        for (int i = 0; i < 40; i++) step(0, 1);
        for (int d = 0; d < 2; d++)
            check(wq[d].size() == 0 && rq[d].size() == 0, "queues_drained",
                  32'(wq[d].size() + rq[d].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitrev_pingpong_ctrl.md
# bitrev_pingpong_ctrl

Parametrised address and flow controller for the FFT input reorder buffer. It accepts channel-interleaved samples into a two-bank (ping-pong) dual-port RAM, then issues bit-reversed read addresses for one channel's frame at a time, so capture and FFT readout overlap. It sits between the stereo ADC sample stream and the FFT core. It drives only RAM addresses and enables and never touches sample data.

## Interface
- BW_FFTP, 9: log2 of FFT points per channel frame (N = 2^BW_FFTP).
- N_CH, 2: channel count; allowed values are 2, 4 and 8. CHB = log2(N_CH).
- REV_ON_RD, 1: 1 = write natural order and read bit-reversed; 0 = write bit-reversed and read natural order.
- AW (localparam) = 1 + CHB + BW_FFTP. Every RAM address is {bank, ch, idx}.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high.
- ClockEn  in  1  global enable. When low, all state and outputs hold.
- Flush  in  1  synchronous abort. Clears counters and bank flags.
- InValid  in  1  input sample present.
- InReady  out  1  controller can accept a sample.
- WE  out  1  RAM write strobe.
- WrAddress  out  AW  RAM write address.
- OutReady  in  1  FFT core can take the next read.
- RdEn  out  1  RAM read strobe.
- RdAddress  out  AW  RAM read address.
- FrameStart  out  1  qualifies the first read of a channel frame (idx 0).
- FrameLast  out  1  qualifies the last read of a channel frame.
- ChOut  out  CHB  channel of the current read.

## Operation
- **Bank state:** Full[1:0] flags, plus write-bank pointer wb and read-bank pointer rb.
- **Write counter:** wcnt = {n, c}. c (LSBs) is the channel and increments first; n is the sample index. Incoming data is interleaved L, R, L, R, …
- **Write acceptance:** a write is accepted when InValid & InReady & ClockEn.
  - WrAddress <= {wb, c, REV_ON_RD ? n : rev(n)}.
  - WE <= 1.
- **End of write frame:** on acceptance at wcnt = all-ones:
  - Full[wb] <= 1, wb toggles, wcnt wraps to 0.
- **InReady:** InReady = ~Full[wb]. When both banks are full, InReady is low and new samples are back-pressured, never dropped.
- **Read counter:** rcnt = {c, k}, channel-major, so each channel's N points are read contiguously.
- **Read issue:** a read is issued when Full[rb] & OutReady & ClockEn.
  - RdAddress <= {rb, c, REV_ON_RD ? rev(k) : k}.
  - RdEn <= 1.
  - ChOut <= c.
  - FrameStart <= (k == 0).
  - FrameLast <= (k == N-1).
- **End of read bank:** on the read at rcnt = all-ones, Full[rb] <= 0, rb toggles and rcnt wraps.
- **Completion in the same cycle:** a write completing bank X and a read completing bank Y (Y ≠ X) in the same cycle both take effect.
- **Strobes when idle:** when no acceptance or read occurs, WE, RdEn, FrameStart and FrameLast are 0. The address outputs hold their previous values.
- **Flush:** clears wcnt, rcnt, Full, wb and rb, and forces all strobes to 0 on the next cycle. Flush has priority over InValid and OutReady.
- **ClockEn low:** freezes everything, including strobes, which hold their last registered value. The RAM must therefore also be gated by ClockEn.

## Timing
- **Reset values:**
  - InReady = 1 (combinational from Full = 0).
  - WE, RdEn, FrameStart, FrameLast = 0.
  - WrAddress, RdAddress, ChOut = 0.
  - wb = rb = 0.
- **Write latency:** WE/WrAddress are registered and appear 1 cycle after acceptance.
- **Read latency:** RdEn/RdAddress are registered and appear 1 cycle after issue. RAM data follows at the RAM's own read latency.
- **First read after frame fill:** Full[wb] is set on the edge of the final accepted write, so the first read of that bank is issued the next cycle, at the earliest 2 cycles after acceptance of the last sample.
- **Back-pressure on input:** InReady drops in the same cycle Full[wb] rises.
- **Back-pressure on output:** OutReady low stalls reads; rcnt holds.
- **Throughput:** with OutReady held high, one read per cycle. A frame of N×N_CH reads takes N×N_CH cycles.

## Structure
- **Shared package fft_pkg:**
  - BW_FFTP default.
  - a bit-reverse function rev(x, width).
  - AW computation and {bank, ch, idx} field offsets, shared with the RAM wrapper and the FFT core.
- **Sub-module bitrev_addr_gen:** a single instance type used twice, once for the write side and once for the read side.
  - Contents: a counter with enable/clear, terminal-count flag and optional bit-reverse output.
  - Parameters: index width, channel width, channel-major vs channel-minor order, reverse enable.
- **Top level:** holds Full, wb, rb, handshakes and output registers.

## Test plan
All scenarios use BW_FFTP = 3, N_CH = 2, REV_ON_RD = 1 (AW = 5) unless stated.
- **Reset:** assert Reset mid-frame after 5 accepted writes → next cycle all outputs are 0, InReady = 1, and the next write goes to WrAddress 0x00.
- **Fill and read bank 0:** 16 writes with OutReady = 1.
  - WrAddress sequence 0x00, 0x08, 0x01, 0x09, … 0x0F.
  - Reads on ch0 at 0x00, 0x04, 0x02, 0x06, 0x01, 0x05, 0x03, 0x07, then ch1 at 0x08 … 0x0F in the same bit-reversed pattern.
  - FrameStart on 0x00 and 0x08; FrameLast on 0x07 and 0x0F.
- **Back-pressure:** OutReady = 0 and 40 InValid cycles → exactly 32 accepted, InReady = 0 from then on. Releasing OutReady → reads from bank 0 (addresses 0x00–0x0F) first, and InReady reasserts the cycle after the read at 0x0F.
- **Simultaneous completion:** final write to bank 1 lands in the same cycle as the final read of bank 0 → Full = 2'b10, and rb = 1 reads 0x10 next cycle.
- **Write-side reversal:** REV_ON_RD = 0 with 16 writes → WrAddress 0x00, 0x08, 0x04, 0x0C, … and reads in natural order 0x00…0x0F.
- **ClockEn and Flush:** ClockEn low for 3 cycles mid-read → RdAddress and strobes frozen, with no skipped address. Flush mid-frame → Full = 0, next read waits for a fresh 16-sample fill.
